// File: rtl/la_capture_readout.sv
// Streams the circular capture BRAM oldest-first on a valid/ready port and reports the trigger's stream position.
// Optional feature macro: LA_READOUT_HEADER_EN prefixes a 3-word header (0xA5, trig_offset low, trig_offset high).
module la_capture_readout #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] wr_last_addr,
  input  logic [ADDR_WIDTH-1:0] trigger_index,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] trig_offset
);
  localparam int unsigned CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] LAST_READ = {1'b0, {ADDR_WIDTH{1'b1}}};

`ifdef LA_READOUT_HEADER_EN
  typedef enum logic [1:0] {S_IDLE, S_HEADER, S_STREAM, S_FLUSH} state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_FLUSH} state_e;
`endif

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [CNT_W-1:0]      rd_cnt_q, rd_cnt_d;
  logic [ADDR_WIDTH-1:0] trig_offset_q, trig_offset_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  pend_q, pend_d;
  logic                  pend_last_q, pend_last_d;
  logic                  head_vld_q, head_vld_d;
  logic [DATA_WIDTH-1:0] head_data_q, head_data_d;
  logic                  head_last_q, head_last_d;
  logic                  skid_vld_q, skid_vld_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
  logic                  skid_last_q, skid_last_d;
`ifdef LA_READOUT_HEADER_EN
  logic [1:0]            hdr_cnt_q, hdr_cnt_d;
`endif

  logic                  pop;
  logic                  room;
  logic [1:0]            occ;
  logic                  push;
  logic [DATA_WIDTH-1:0] push_data;
  logic                  push_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      rd_addr_q     <= '0;
      rd_cnt_q      <= '0;
      trig_offset_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pend_q        <= 1'b0;
      pend_last_q   <= 1'b0;
      head_vld_q    <= 1'b0;
      head_data_q   <= '0;
      head_last_q   <= 1'b0;
      skid_vld_q    <= 1'b0;
      skid_data_q   <= '0;
      skid_last_q   <= 1'b0;
`ifdef LA_READOUT_HEADER_EN
      hdr_cnt_q     <= '0;
`endif
    end else begin
      state_q       <= state_d;
      rd_addr_q     <= rd_addr_d;
      rd_cnt_q      <= rd_cnt_d;
      trig_offset_q <= trig_offset_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      pend_q        <= pend_d;
      pend_last_q   <= pend_last_d;
      head_vld_q    <= head_vld_d;
      head_data_q   <= head_data_d;
      head_last_q   <= head_last_d;
      skid_vld_q    <= skid_vld_d;
      skid_data_q   <= skid_data_d;
      skid_last_q   <= skid_last_d;
`ifdef LA_READOUT_HEADER_EN
      hdr_cnt_q     <= hdr_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d       = state_q;
    rd_addr_d     = rd_addr_q;
    rd_cnt_d      = rd_cnt_q;
    trig_offset_d = trig_offset_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    pend_d        = 1'b0;
    pend_last_d   = 1'b0;
    head_vld_d    = head_vld_q;
    head_data_d   = head_data_q;
    head_last_d   = head_last_q;
    skid_vld_d    = skid_vld_q;
    skid_data_d   = skid_data_q;
    skid_last_d   = skid_last_q;
`ifdef LA_READOUT_HEADER_EN
    hdr_cnt_d     = hdr_cnt_q;
`endif
    rd_en         = 1'b0;

    // rd_en looks at this cycle's m_ready so a 2-entry buffer sustains one word per clock
    pop       = head_vld_q & m_ready;
    occ       = 2'(pend_q) + 2'(head_vld_q) + 2'(skid_vld_q);
    room      = (occ < 2'd2) || ((occ == 2'd2) && pop);
    push      = pend_q;
    push_data = rd_data;
    push_last = pend_last_q;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          rd_addr_d     = wr_last_addr + ADDR_WIDTH'(1);
          trig_offset_d = trigger_index - wr_last_addr - ADDR_WIDTH'(1);
          rd_cnt_d      = '0;
          busy_d        = 1'b1;
`ifdef LA_READOUT_HEADER_EN
          hdr_cnt_d     = '0;
          state_d       = S_HEADER;
`else
          state_d       = S_STREAM;
`endif
        end
      end
`ifdef LA_READOUT_HEADER_EN
      S_HEADER: begin
        if (room) begin
          push      = 1'b1;
          push_last = 1'b0;
          case (hdr_cnt_q)
            2'd0:    push_data = DATA_WIDTH'(8'hA5);
            2'd1:    push_data = DATA_WIDTH'(trig_offset_q);
            default: push_data = DATA_WIDTH'(trig_offset_q >> DATA_WIDTH);
          endcase
          hdr_cnt_d = hdr_cnt_q + 2'd1;
          if (hdr_cnt_q == 2'd2) state_d = S_STREAM;
        end
      end
`endif
      S_STREAM: begin
        if (room) begin
          rd_en       = 1'b1;
          rd_addr_d   = rd_addr_q + ADDR_WIDTH'(1);
          rd_cnt_d    = rd_cnt_q + CNT_W'(1);
          pend_d      = 1'b1;
          pend_last_d = (rd_cnt_q == LAST_READ);
          if (rd_cnt_q == LAST_READ) state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (pop && head_last_q) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Skid buffer: head drives the stream, second entry absorbs data arriving during a stall
    if (pop) begin
      if (skid_vld_q) begin
        head_data_d = skid_data_q;
        head_last_d = skid_last_q;
        skid_vld_d  = 1'b0;
      end else begin
        head_vld_d  = 1'b0;
      end
    end
    if (push) begin
      if (!head_vld_d) begin
        head_vld_d  = 1'b1;
        head_data_d = push_data;
        head_last_d = push_last;
      end else begin
        skid_vld_d  = 1'b1;
        skid_data_d = push_data;
        skid_last_d = push_last;
      end
    end

    if (abort) begin
      state_d     = S_IDLE;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      rd_en       = 1'b0;
      pend_d      = 1'b0;
      pend_last_d = 1'b0;
      head_vld_d  = 1'b0;
      skid_vld_d  = 1'b0;
    end
  end

  assign rd_addr     = rd_addr_q;
  assign m_valid     = head_vld_q;
  assign m_data      = head_data_q;
  assign m_last      = head_last_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign trig_offset = trig_offset_q;

endmodule

// File: tb/tb_la_capture_readout.sv
// Bench for la_capture_readout: BRAM model mem[i]=i+0x10, directed and random readouts checked
// against a queue-based model of the chronological stream.
module tb_la_capture_readout;
  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;
  localparam int N = 1 << AW;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [AW-1:0] wr_last_addr;
  logic [AW-1:0] trigger_index;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          m_ready;
  logic          busy;
  logic          done;
  logic [AW-1:0] trig_offset;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int          ready_mode = 0;
  int unsigned cyc = 0;

  logic [DW:0]   got_q[$];
  int unsigned   got_cyc[$];
  logic [AW-1:0] rd_q[$];
  logic [DW-1:0] mem [N];

  la_capture_readout #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .wr_last_addr(wr_last_addr), .trigger_index(trigger_index),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
    .busy(busy), .done(done), .trig_offset(trig_offset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial for (int i = 0; i < N; i++) mem[i] = DW'(i + 16);
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  // Downstream ready: 0 = always, 1 = fixed 1,0,0,1,0,1 pattern, 2 = random
  initial begin
    logic pat [6];
    int   pidx;
    pat  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    pidx = 0;
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       m_ready = 1'b1;
        1:       begin m_ready = pat[pidx]; pidx = (pidx + 1) % 6; end
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Records transfers and read addresses; checks payload holds steady through stalls
  initial begin
    logic          prev_stall;
    logic [DW-1:0] prev_d;
    logic          prev_l;
    prev_stall = 1'b0;
    prev_d     = '0;
    prev_l     = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (prev_stall && abort !== 1'b1) begin
        n_cmp++;
        assert (m_valid === 1'b1 && m_data === prev_d && m_last === prev_l) else begin
          n_bad++;
          $error("FAIL stall_hold: observed v=%b d=%h l=%b expected v=1 d=%h l=%b",
                 m_valid, m_data, m_last, prev_d, prev_l);
        end
      end
      if (m_valid === 1'b1 && m_ready === 1'b1) begin
        got_q.push_back({m_last, m_data});
        got_cyc.push_back(cyc);
      end
      if (rd_en === 1'b1) rd_q.push_back(rd_addr);
      prev_stall = (m_valid === 1'b1) && (m_ready === 1'b0);
      prev_d     = m_data;
      prev_l     = m_last;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic run(input int wl, input int ti, input int mode, input int abort_at,
                     input int restart_at, input string tag);
    logic [DW:0] exp_q[$];
    int base, off, quiet, lim;
    bit done_seen, aborted, restarted;
    base = (wl + 1) % N;
    off  = (ti + 2 * N - wl - 1) % N;
`ifdef LA_READOUT_HEADER_EN
    exp_q.push_back({1'b0, DW'(8'hA5)});
    exp_q.push_back({1'b0, DW'(off % 256)});
    exp_q.push_back({1'b0, DW'(off / 256)});
`endif
    for (int k = 0; k < N; k++) exp_q.push_back({k == N - 1, DW'((base + k) % N + 16)});

    step();
    got_q.delete();
    got_cyc.delete();
    rd_q.delete();
    ready_mode    = mode;
    wr_last_addr  = AW'(wl);
    trigger_index = AW'(ti);
    start         = 1'b1;
    step();
    start         = 1'b0;
    wr_last_addr  = AW'($urandom);
    trigger_index = AW'($urandom);
    check({tag, "/busy_rise"}, 32'(busy), 32'd1);
    check({tag, "/trig_offset"}, 32'(trig_offset), 32'(off));
`ifndef LA_READOUT_HEADER_EN
    if (mode == 0) begin
      check({tag, "/valid_c1"}, 32'(m_valid), 32'd0);
      step();
      check({tag, "/valid_c2"}, 32'(m_valid), 32'd0);
      step();
      check({tag, "/valid_c3"}, 32'(m_valid), 32'd1);
      check({tag, "/first_word"}, 32'(m_data), 32'(exp_q[0][DW-1:0]));
    end
`endif

    done_seen = 1'b0;
    aborted   = 1'b0;
    restarted = 1'b0;
    for (int g = 0; g < 400 && !done_seen && !aborted; g++) begin
      step();
      if (done === 1'b1) begin
        done_seen = 1'b1;
      end else if (abort_at >= 0 && got_q.size() >= abort_at) begin
        abort = 1'b1;
        step();
        abort   = 1'b0;
        aborted = 1'b1;
        check({tag, "/abort_valid"}, 32'(m_valid), 32'd0);
        check({tag, "/abort_busy"}, 32'(busy), 32'd0);
        check({tag, "/abort_done"}, 32'(done), 32'd0);
      end else if (restart_at >= 0 && !restarted && got_q.size() >= restart_at) begin
        start         = 1'b1;
        wr_last_addr  = AW'($urandom);
        trigger_index = AW'($urandom);
        step();
        start     = 1'b0;
        restarted = 1'b1;
      end
    end

    if (aborted) begin
      quiet = 0;
      for (int i = 0; i < 10; i++) begin
        step();
        if (done === 1'b1 || m_valid === 1'b1 || busy === 1'b1) quiet++;
      end
      check({tag, "/abort_quiet"}, 32'(quiet), 32'd0);
      check({tag, "/abort_count"}, 32'(got_q.size()), 32'(abort_at));
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
        check($sformatf("%s/word%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    end else begin
      check({tag, "/done_seen"}, 32'(done_seen), 32'd1);
      check({tag, "/busy_fall"}, 32'(busy), 32'd0);
      check({tag, "/count"}, 32'(got_q.size()), 32'(exp_q.size()));
      lim = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < lim; i++)
        check($sformatf("%s/word%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
      step();
      check({tag, "/done_width"}, 32'(done), 32'd0);
      check({tag, "/trig_hold"}, 32'(trig_offset), 32'(off));
      check({tag, "/reads"}, 32'(rd_q.size()), 32'(N));
      for (int k = 0; k < rd_q.size() && k < N; k++)
        check($sformatf("%s/rd_addr%0d", tag, k), 32'(rd_q[k]), 32'((base + k) % N));
`ifndef LA_READOUT_HEADER_EN
      if (mode == 0 && got_cyc.size() == N)
        check({tag, "/back_to_back"}, got_cyc[N-1] - got_cyc[0], 32'(N - 1));
`endif
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    start         = 1'b0;
    abort         = 1'b0;
    wr_last_addr  = '0;
    trigger_index = '0;
    repeat (3) step();
    check("reset_outputs", 32'({rd_en, rd_addr, m_valid, m_data, m_last, busy, done, trig_offset}), 32'd0);
    rst_n = 1'b1;
    step();
    check("post_reset_outputs", 32'({rd_en, rd_addr, m_valid, m_data, m_last, busy, done, trig_offset}), 32'd0);

    // abort wins over start in the same cycle
    start         = 1'b1;
    abort         = 1'b1;
    wr_last_addr  = AW'(3);
    trigger_index = AW'(9);
    step();
    start = 1'b0;
    abort = 1'b0;
    check("abort_beats_start_busy", 32'(busy), 32'd0);
    step();
    check("abort_beats_start_idle", 32'({busy, m_valid, rd_en}), 32'd0);
    check("abort_beats_start_offset", 32'(trig_offset), 32'd0);

    run(5, 9, 0, -1, -1, "basic");
    run(15, 0, 0, -1, -1, "wrap");
    run(5, 9, 1, -1, -1, "backpressure");
    run(5, 9, 0, 4, -1, "abort");
    run(10, 2, 0, -1, -1, "after_abort");
    run(5, 9, 1, -1, 6, "restart_ignored");
    for (int r = 0; r < 4; r++)
      run(int'($urandom_range(0, N - 1)), int'($urandom_range(0, N - 1)), 2, -1, -1,
          $sformatf("random%0d", r));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
